pipe_ctrl_chain: RTL and testbench

Parametrised control-signal pipeline that carries the decoded control bundle from decode through `STAGES` downstream pipeline stages (default E, M, W). Each stage has a valid bit, per-stage stall and flush, automatic bubble insertion behind a stalled stage, and a registered "was held" flag per stage for multicycle units such as the divider. It replaces the fixed-width, hand-wired stage registers in the controller with one generic chain. It also carries a saturating bubble counter on the final stage for performance monitoring.

---
 rtl/pipe_ctrl_chain_pkg.sv | 50 +++++
 rtl/pipe_ctrl_stage.sv | 61 ++++++
 rtl/pipe_ctrl_chain.sv | 93 +++++++++
 tb/tb_pipe_ctrl_chain.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_chain_pkg.sv
// Shared definitions for the control-signal pipeline: stage indices, bundle field
// offsets and the per-stage update priority.
`ifndef DEFINE_PIPE_CTRL_VH
`define DEFINE_PIPE_CTRL_VH
`define PIPE_E 0
`define PIPE_M 1
`define PIPE_W 2
`endif

package pipe_ctrl_chain_pkg;

  localparam int unsigned PipeE = 0;
  localparam int unsigned PipeM = 1;
  localparam int unsigned PipeW = 2;

  // Bit offsets of the named fields inside one W-bit control bundle.
  localparam int unsigned CtrlMemtoreg     = 0;
  localparam int unsigned CtrlMemwrite     = 1;
  localparam int unsigned CtrlAlusrc       = 2;
  localparam int unsigned CtrlRegdst       = 3;
  localparam int unsigned CtrlRegwrite     = 4;
  localparam int unsigned CtrlAlucontrol   = 5;
  localparam int unsigned CtrlAlucontrolW  = 5;
  localparam int unsigned CtrlHiloWrite    = 10;
  localparam int unsigned CtrlUsedBits     = 11;

  typedef enum logic [1:0] {
    ActLoad,
    ActBubble,
    ActHold,
    ActFlush
  } stageAct_e;

  // Flush beats hold, hold beats bubble insertion, bubble beats a normal load.
  function automatic stageAct_e stageAction(input logic flush, input logic hold,
                                            input logic prevHold);
    stageAct_e act;
    if (flush) begin
      act = ActFlush;
    end else if (hold) begin
      act = ActHold;
    end else if (prevHold) begin
      act = ActBubble;
    end else begin
      act = ActLoad;
    end
    return act;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stage.sv
// One pipeline stage: valid flop plus W-bit control payload with flush/hold/bubble/load
// selection. Payload is forced to zero whenever the stage is invalid.
module pipe_ctrl_stage
  import pipe_ctrl_chain_pkg::*;
#(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         hold,
  input  logic         prevHold,
  input  logic         loadValid,
  input  logic [W-1:0] loadCtrl,
  output logic         stageValid,
  output logic [W-1:0] stageCtrl
);

  logic         validQ, validD;
  logic [W-1:0] ctrlQ, ctrlD;
  stageAct_e    act;

  assign act = stageAction(flush, hold, prevHold);

  always_comb begin
    validD = validQ;
    ctrlD  = ctrlQ;
    unique case (act)
      ActFlush, ActBubble: begin
        validD = 1'b0;
        ctrlD  = '0;
      end
      ActHold: begin
        validD = validQ;
        ctrlD  = ctrlQ;
      end
      ActLoad: begin
        validD = loadValid;
        ctrlD  = loadValid ? loadCtrl : '0;
      end
      default: begin
        validD = 1'b0;
        ctrlD  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validQ <= 1'b0;
      ctrlQ  <= '0;
    end else begin
      validQ <= validD;
      ctrlQ  <= ctrlD;
    end
  end

  assign stageValid = validQ;
  assign stageCtrl  = ctrlQ;

endmodule

// File: rtl/pipe_ctrl_chain.sv
// Generic control-bundle pipeline from decode through STAGES stages, with a stall-driven
// hold chain, per-stage held flags and a saturating bubble counter on the last stage.
module pipe_ctrl_chain
  import pipe_ctrl_chain_pkg::*;
#(
  parameter int unsigned W      = 12,
  parameter int unsigned STAGES = 3,
  parameter int unsigned CNTW   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [W-1:0]          in_ctrl,
  output logic                  in_ready,
  input  logic [STAGES-1:0]     stall,
  input  logic [STAGES-1:0]     flush,
  input  logic                  cnt_clr,
  output logic [STAGES-1:0]     stage_valid,
  output logic [STAGES*W-1:0]   stage_ctrl,
  output logic [STAGES-1:0]     stage_held,
  output logic [CNTW-1:0]       bubble_cnt
);

  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] heldQ;
  logic [CNTW-1:0]   cntQ, cntD;

  for (genvar s = 0; s < STAGES; s++) begin : gStage
    logic         prevHold;
    logic         loadValid;
    logic [W-1:0] loadCtrl;

    // A stall freezes its own stage and everything upstream of it.
    assign hold[s] = |stall[STAGES-1:s];

    if (s == 0) begin : gHead
      assign prevHold  = 1'b0;
      assign loadValid = in_valid;
      assign loadCtrl  = in_ctrl;
    end else begin : gBody
      assign prevHold  = hold[s-1];
      assign loadValid = stage_valid[s-1];
      assign loadCtrl  = stage_ctrl[(s-1)*W +: W];
    end

    pipe_ctrl_stage #(
      .W (W)
    ) uStage (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush[s]),
      .hold       (hold[s]),
      .prevHold   (prevHold),
      .loadValid  (loadValid),
      .loadCtrl   (loadCtrl),
      .stageValid (stage_valid[s]),
      .stageCtrl  (stage_ctrl[s*W +: W])
    );
  end

  assign in_ready = ~hold[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      heldQ <= '0;
    end else begin
      heldQ <= hold;
    end
  end

  assign stage_held = heldQ;

  // Clear beats increment; the counter sticks at all-ones.
  always_comb begin
    cntD = cntQ;
    if (cnt_clr) begin
      cntD = '0;
    end else if (!stage_valid[STAGES-1] && (cntQ != {CNTW{1'b1}})) begin
      cntD = cntQ + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cntQ <= '0;
    end else begin
      cntQ <= cntD;
    end
  end

  assign bubble_cnt = cntQ;

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Directed self-checking bench for pipe_ctrl_chain (W=12, STAGES=3, CNTW=4).
module tb_pipe_ctrl_chain;

  localparam int unsigned W      = 12;
  localparam int unsigned STAGES = 3;
  localparam int unsigned CNTW   = 4;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic [W-1:0]        in_ctrl;
  logic                in_ready;
  logic [STAGES-1:0]   stall;
  logic [STAGES-1:0]   flush;
  logic                cnt_clr;
  logic [STAGES-1:0]   stage_valid;
  logic [STAGES*W-1:0] stage_ctrl;
  logic [STAGES-1:0]   stage_held;
  logic [CNTW-1:0]     bubble_cnt;

  int checks = 0;
  int errors = 0;

  pipe_ctrl_chain #(
    .W      (W),
    .STAGES (STAGES),
    .CNTW   (CNTW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ctrl     (in_ctrl),
    .in_ready    (in_ready),
    .stall       (stall),
    .flush       (flush),
    .cnt_clr     (cnt_clr),
    .stage_valid (stage_valid),
    .stage_ctrl  (stage_ctrl),
    .stage_held  (stage_held),
    .bubble_cnt  (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_ctrl  = '0;
    stall    = '0;
    flush    = '0;
    cnt_clr  = 1'b0;
    #1;
    chk("rst_valid", 64'(stage_valid), 64'h0);
    chk("rst_ctrl",  64'(stage_ctrl),  64'h0);
    chk("rst_held",  64'(stage_held),  64'h0);
    chk("rst_cnt",   64'(bubble_cnt),  64'h0);
    chk("rst_ready", 64'(in_ready),    64'h1);

    // Free flow: 0x001..0x003 on consecutive edges.
    repeat (2) @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_ctrl  = 12'h001;
    step();
    chk("ff_e1_ctrl", 64'(stage_ctrl), 64'h0000_00001);
    chk("ff_e1_cnt",  64'(bubble_cnt), 64'h1);
    in_ctrl = 12'h002;
    step();
    in_ctrl = 12'h003;
    step();
    chk("ff_e3_ctrl",  64'(stage_ctrl),  {28'h0, 12'h001, 12'h002, 12'h003});
    chk("ff_e3_valid", 64'(stage_valid), 64'h7);
    chk("ff_e3_cnt",   64'(bubble_cnt),  64'h3);
    in_valid = 1'b0;
    step();
    chk("ff_e4_ctrl",  64'(stage_ctrl),  {28'h0, 12'h002, 12'h003, 12'h000});
    chk("ff_e4_valid", 64'(stage_valid), 64'h6);
    step();
    chk("ff_e5_ctrl",  64'(stage_ctrl),  {28'h0, 12'h003, 12'h000, 12'h000});
    chk("ff_e5_cnt",   64'(bubble_cnt),  64'h3);

    // Middle stall: 0x0A1 in stage 1, 0x0A0 in stage 0, stall[1] for two cycles.
    in_valid = 1'b1;
    in_ctrl  = 12'h0A1;
    step();
    in_ctrl = 12'h0A0;
    step();
    chk("ms_pre_ctrl", 64'(stage_ctrl), {28'h0, 12'h000, 12'h0A1, 12'h0A0});
    chk("ms_pre_cnt",  64'(bubble_cnt), 64'h4);
    in_ctrl = 12'h0A2;
    stall   = 3'b010;
    #1;
    chk("ms_ready", 64'(in_ready), 64'h0);
    step();
    chk("ms_s1_ctrl",  64'(stage_ctrl),  {28'h0, 12'h000, 12'h0A1, 12'h0A0});
    chk("ms_s1_valid", 64'(stage_valid), 64'h3);
    chk("ms_s1_held",  64'(stage_held),  64'h3);
    chk("ms_ready2",   64'(in_ready),    64'h0);
    step();
    chk("ms_s2_ctrl",  64'(stage_ctrl),  {28'h0, 12'h000, 12'h0A1, 12'h0A0});
    chk("ms_s2_valid", 64'(stage_valid), 64'h3);
    chk("ms_s2_held",  64'(stage_held),  64'h3);
    chk("ms_s2_cnt",   64'(bubble_cnt),  64'h6);
    stall = '0;
    #1;
    chk("ms_ready_rel", 64'(in_ready), 64'h1);
    step();
    chk("ms_rel_ctrl",  64'(stage_ctrl),  {28'h0, 12'h0A1, 12'h0A0, 12'h0A2});
    chk("ms_rel_valid", 64'(stage_valid), 64'h7);
    chk("ms_rel_held",  64'(stage_held),  64'h0);
    chk("ms_rel_cnt",   64'(bubble_cnt),  64'h7);

    // Flush over stall on stage 0 holding 0x5A5.
    in_ctrl = 12'h5A5;
    step();
    chk("fs_pre_ctrl", 64'(stage_ctrl), {28'h0, 12'h0A0, 12'h0A2, 12'h5A5});
    in_ctrl = 12'h111;
    stall   = 3'b001;
    flush   = 3'b001;
    step();
    chk("fs_f_ctrl",  64'(stage_ctrl),  {28'h0, 12'h0A2, 12'h000, 12'h000});
    chk("fs_f_valid", 64'(stage_valid), 64'h4);
    flush = '0;
    step();
    chk("fs_h_ctrl",  64'(stage_ctrl),  64'h0);
    chk("fs_h_valid", 64'(stage_valid), 64'h0);
    chk("fs_h_held",  64'(stage_held),  64'h1);
    chk("fs_h_cnt",   64'(bubble_cnt),  64'h7);
    stall   = '0;
    in_ctrl = 12'h123;
    step();
    chk("fs_rel_ctrl", 64'(stage_ctrl), {28'h0, 12'h000, 12'h000, 12'h123});
    chk("fs_rel_cnt",  64'(bubble_cnt), 64'h8);

    // Async reset with all stages valid.
    in_ctrl = 12'h124;
    step();
    in_ctrl = 12'h125;
    step();
    chk("ar_pre_ctrl",  64'(stage_ctrl),  {28'h0, 12'h123, 12'h124, 12'h125});
    chk("ar_pre_valid", 64'(stage_valid), 64'h7);
    chk("ar_pre_cnt",   64'(bubble_cnt),  64'hA);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_valid", 64'(stage_valid), 64'h0);
    chk("ar_ctrl",  64'(stage_ctrl),  64'h0);
    chk("ar_cnt",   64'(bubble_cnt),  64'h0);
    in_ctrl = 12'h0C7;
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("ar_post_ctrl",  64'(stage_ctrl),  64'h0C7);
    chk("ar_post_valid", 64'(stage_valid), 64'h1);
    chk("ar_post_cnt",   64'(bubble_cnt),  64'h1);

    // Drain, then counter saturation and clear on an empty chain.
    in_valid = 1'b0;
    repeat (3) step();
    chk("cs_drain_valid", 64'(stage_valid), 64'h0);
    chk("cs_drain_cnt",   64'(bubble_cnt),  64'h3);
    cnt_clr = 1'b1;
    step();
    chk("cs_clr0", 64'(bubble_cnt), 64'h0);
    cnt_clr = 1'b0;
    repeat (15) step();
    chk("cs_sat", 64'(bubble_cnt), 64'hF);
    repeat (2) step();
    chk("cs_sat_hold", 64'(bubble_cnt), 64'hF);
    cnt_clr = 1'b1;
    step();
    chk("cs_clr", 64'(bubble_cnt), 64'h0);
    cnt_clr = 1'b0;
    step();
    chk("cs_inc", 64'(bubble_cnt), 64'h1);

    // Invalid input with all-ones payload.
    in_valid = 1'b0;
    in_ctrl  = 12'hFFF;
    step();
    chk("iv_valid", 64'(stage_valid), 64'h0);
    chk("iv_ctrl",  64'(stage_ctrl),  64'h0);

    // Simultaneous stall on all stages: frozen chain, counter still runs.
    in_valid = 1'b1;
    in_ctrl  = 12'h3C3;
    step();
    stall = 3'b111;
    step();
    chk("as_ctrl", 64'(stage_ctrl), 64'h3C3);
    chk("as_held", 64'(stage_held), 64'h7);
    chk("as_cnt",  64'(bubble_cnt), 64'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
